tally_window_sched: RTL
=======================

# tally_window_sched

Sequencer that time-shares the single `current_counter` event tallier between NUM_CH input signals. For each enabled channel in round-robin order it clears the counter, gates that channel's signal into it for a fixed window, waits for the tally to settle, and presents the captured count with a valid/ready handshake. It sits between the raw input signals and the downstream logger/display. It runs either single-shot (one pass over enabled channels) or continuously.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (≥2)
- WIDTH, 32, tally/result width (matches counter `tally_out`)
- WINDOW, 1000, count-window length in clk_in cycles (≥1)
- SETTLE, 2, cycles between window close and tally capture (≥1)

Ports (one clock; reset is synchronous and active-low):
- clk_in  input  1  system clock, all logic on rising edge
- rst_in  input  1  synchronous reset, active-low
- start_in  input  1  begin pass; sampled in IDLE only
- stop_in  input  1  abort; returns to IDLE
- continuous_in  input  1  1 = wrap and repeat passes
- ch_en_in  input  NUM_CH  channel enable mask
- signal_in  input  NUM_CH  raw channel signals
- ctr_rst_out  output  1  drives counter `rst_in` (active-high clear)
- ctr_signal_out  output  1  drives counter `signal_in`
- ctr_tally_in  input  WIDTH  counter `tally_out`
- result_out  output  WIDTH  captured tally
- result_ch_out  output  $clog2(NUM_CH)  channel of result_out
- result_valid_out  output  1  result available
- result_ready_in  input  1  consumer accepts
- busy_out  output  1  high in any state except IDLE
- done_out  output  1  one-cycle pulse at end of single-shot pass

## Operation
- States: IDLE, CLEAR, COUNT, SETTLE, REPORT.
- IDLE: ctr_rst_out=1, ctr_signal_out=0. start_in=1, stop_in=0 and ch_en_in≠0 → CLEAR. ch = lowest set bit of ch_en_in. Otherwise stay.
- CLEAR (1 cycle): ctr_rst_out=1 → COUNT. Window counter is zeroed.
- COUNT (WINDOW cycles): ctr_rst_out=0, ctr_signal_out = signal_in[ch], combinational pass-through. The window counter runs 0..WINDOW-1; at WINDOW-1 → SETTLE.
- SETTLE (SETTLE cycles): ctr_signal_out=0. On the last cycle, result_out←ctr_tally_in and result_ch_out←ch → REPORT.
- REPORT: result_valid_out=1. result_out and result_ch_out hold stable until valid&ready. The counter is not cleared here.
- On handshake, next ch = first set bit of ch_en_in (sampled that cycle) strictly after ch, wrapping modulo NUM_CH:
  - No wrap → CLEAR with the next ch.
  - Wrap (or the mask is now 0) and continuous_in=0 → done_out pulse, IDLE.
  - Wrap and continuous_in=1 with mask≠0 → CLEAR. A single enabled channel re-selects itself.
  - continuous_in=1 but mask=0 → IDLE with no done_out.
- stop_in=1 in any non-IDLE state → IDLE on the next edge. It drops result_valid_out and raises no done_out; stop_in wins over start_in and over a same-cycle handshake.
- start_in outside IDLE is ignored. ch_en_in changes are only observed at start and at handshake.

## Timing
- Reset (rst_in=0 at an edge) from any state → IDLE. Reset values:
  - ctr_rst_out=1
  - ctr_signal_out=0
  - result_out=0
  - result_ch_out=0
  - result_valid_out=0
  - busy_out=0
  - done_out=0
- start sampled at edge 0:
  - CLEAR during cycle 1.
  - COUNT during cycles 2..WINDOW+1.
  - SETTLE during cycles WINDOW+2..WINDOW+SETTLE+1.
  - result_valid_out high from cycle WINDOW+SETTLE+2.
- Handshake → next CLEAR in the following cycle, so the per-channel period is WINDOW+SETTLE+2 cycles with ready held high.
- done_out is high for exactly the cycle after the final handshake, coincident with the first IDLE cycle. busy_out is already 0 in that cycle.
- All outputs are registered except ctr_signal_out.

## Test plan
Bench setup: WINDOW=16, SETTLE=2, NUM_CH=4, behavioural counter counting rising edges of ctr_signal_out.
- Single-shot, ch_en=0101, ch0 square wave period 4, ch2 held 0, ready=1:
  - results (ch0, 4) then (ch2, 0).
  - valid first at start+20.
  - done_out pulses once, then IDLE.
- Backpressure: ready=0 for 10 cycles in REPORT:
  - valid, result_out and result_ch_out stay constant.
  - ctr_rst_out stays 0, no CLEAR.
  - CLEAR occurs the cycle after ready rises.
- Continuous, ch_en=1000, ch3 held 1:
  - repeated results (ch3, 1), one gating edge per window.
  - Drop continuous_in → pass ends after the current handshake with done_out=1.
- stop_in mid-COUNT:
  - IDLE next cycle, ctr_rst_out=1, busy_out=0, no valid, no done.
  - start_in and stop_in asserted together in IDLE → stays IDLE.
- rst_in low for 1 cycle while in REPORT → all outputs at reset values next cycle; a subsequent start behaves normally.
- Ignored starts:
  - start with ch_en=0 → remains IDLE.
  - start pulses during COUNT → no effect on sequence or results.

Source files
------------

// File: rtl/tally_window_sched.sv
// tally_window_sched: round-robin sequencer that time-shares one event
// tallier across NUM_CH signals and reports each window's count.
module tally_window_sched #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int WINDOW = 1000,
  parameter int SETTLE = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic                      stop_in,
  input  logic                      continuous_in,
  input  logic [NUM_CH-1:0]         ch_en_in,
  input  logic [NUM_CH-1:0]         signal_in,
  output logic                      ctr_rst_out,
  output logic                      ctr_signal_out,
  input  logic [WIDTH-1:0]          ctr_tally_in,
  output logic [WIDTH-1:0]          result_out,
  output logic [$clog2(NUM_CH)-1:0] result_ch_out,
  output logic                      result_valid_out,
  input  logic                      result_ready_in,
  output logic                      busy_out,
  output logic                      done_out
);

  localparam int CW = $clog2(NUM_CH);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_SETTLE,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    ch_q, ch_d;
  logic [WW-1:0]    win_q, win_d;
  logic [SW-1:0]    set_q, set_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    rch_q, rch_d;
  logic             done_d;

  logic             ctr_rst_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;

  logic [CW-1:0]    low_idx;
  logic [CW-1:0]    nxt_idx;
  logic             nxt_found;

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    low_idx   = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en_in[i]) begin
        low_idx = CW'(i);
      end
      if (ch_en_in[i] && (CW'(i) > ch_q)) begin
        nxt_idx   = CW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    win_d   = win_q;
    set_d   = set_q;
    res_d   = res_q;
    rch_d   = rch_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_in && !stop_in && (|ch_en_in)) begin
          state_d = S_CLEAR;
          ch_d    = low_idx;
        end
      end
      S_CLEAR: begin
        win_d   = '0;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (win_q == WW'(WINDOW - 1)) begin
          set_d   = '0;
          state_d = S_SETTLE;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (set_q == SW'(SETTLE - 1)) begin
          res_d   = ctr_tally_in;
          rch_d   = ch_q;
          state_d = S_REPORT;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      S_REPORT: begin
        if (result_ready_in) begin
          if (nxt_found) begin
            ch_d    = nxt_idx;
            state_d = S_CLEAR;
          end else if (continuous_in && (|ch_en_in)) begin
            ch_d    = low_idx;
            state_d = S_CLEAR;
          end else begin
            state_d = S_IDLE;
            done_d  = !continuous_in;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any handshake or pass completion.
    if (stop_in && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      win_q     <= '0;
      set_q     <= '0;
      res_q     <= '0;
      rch_q     <= '0;
      ctr_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      win_q     <= win_d;
      set_q     <= set_d;
      res_q     <= res_d;
      rch_q     <= rch_d;
      ctr_rst_q <= (state_d == S_IDLE) || (state_d == S_CLEAR);
      busy_q    <= (state_d != S_IDLE);
      valid_q   <= (state_d == S_REPORT);
      done_q    <= done_d;
    end
  end

  assign ctr_signal_out   = (state_q == S_COUNT) && signal_in[ch_q];
  assign ctr_rst_out      = ctr_rst_q;
  assign result_out       = res_q;
  assign result_ch_out    = rch_q;
  assign result_valid_out = valid_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;

endmodule
